md_unit_param: RTL and testbench

//  Parametrised multiply/divide unit for the pipelined MIPS core (EX stage). Accepts one

---
 rtl/md_pkg.sv | 71 +++++++
 rtl/md_datapath.sv | 85 ++++++++
 rtl/md_unit_param.sv | 101 ++++++++++
 tb/tb_md_unit_param.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: opcode encodings and decode helpers for the multiply/divide unit.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
`timescale 1ns/1ps
package md_pkg;

   localparam int unsigned MD_OP_W = 4;

   localparam logic [MD_OP_W-1:0] MD_NOP   = 4'd0;
   localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;
   localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd9;
   localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd10;
   localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd11;
   localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd12;

   // How a completed result is merged into {hi,lo}
   typedef enum logic [1:0] {
      ACC_NONE = 2'd0,
      ACC_ADD  = 2'd1,
      ACC_SUB  = 2'd2
   } md_acc_e;

   function automatic logic is_mul(input logic [MD_OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic is_div(input logic [MD_OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_madd(input logic [MD_OP_W-1:0] op);
`ifdef MD_MADD_EN
      return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
      return (op != op);
`endif
   endfunction

   function automatic logic is_arith(input logic [MD_OP_W-1:0] op);
      return is_mul(op) || is_div(op) || is_madd(op);
   endfunction

   function automatic logic is_legal(input logic [MD_OP_W-1:0] op);
      return is_arith(op) || (op == MD_MTHI) || (op == MD_MTLO);
   endfunction

   function automatic int unsigned lat_of(input logic [MD_OP_W-1:0] op,
                                          input int unsigned mult_lat,
                                          input int unsigned div_lat);
      if (is_div(op))
         return div_lat;
      else if (is_arith(op))
         return mult_lat;
      else
         return 0;
   endfunction

   function automatic md_acc_e acc_of(input logic [MD_OP_W-1:0] op);
      if ((op == MD_MADD) || (op == MD_MADDU))
         return ACC_ADD;
      else if ((op == MD_MSUB) || (op == MD_MSUBU))
         return ACC_SUB;
      else
         return ACC_NONE;
   endfunction

endpackage

// File: rtl/md_datapath.sv
// md_datapath: combinational multiply/divide result generator.
// Produces {res_hi,res_lo} for the requested op, with defined results for
// divide-by-zero and signed MIN/-1 overflow.
// Optional feature macro: MD_MADD_EN (MADD-family ops return the raw product).
`timescale 1ns/1ps
module md_datapath
   import md_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [MD_OP_W-1:0] op,
   input  logic [DATA_W-1:0]  d1,
   input  logic [DATA_W-1:0]  d2,
   output logic [DATA_W-1:0]  res_hi,
   output logic [DATA_W-1:0]  res_lo
);

   localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

   logic signed [2*DATA_W-1:0] prod_s;
   logic        [2*DATA_W-1:0] prod_u;
   logic signed [DATA_W-1:0]   q_s;
   logic signed [DATA_W-1:0]   r_s;
   logic        [DATA_W-1:0]   q_u;
   logic        [DATA_W-1:0]   r_u;
   logic        [DATA_W-1:0]   div_s_den;
   logic        [DATA_W-1:0]   div_u_den;
   logic                       div_zero;
   logic                       div_ovf;

   // Products and quotients; divisors are forced to 1 in the special cases so
   // the raw dividers never see a trapping operand pair.
   always_comb begin
      prod_s    = $signed({{DATA_W{d1[DATA_W-1]}}, d1}) * $signed({{DATA_W{d2[DATA_W-1]}}, d2});
      prod_u    = {{DATA_W{1'b0}}, d1} * {{DATA_W{1'b0}}, d2};
      div_zero  = (d2 == '0);
      div_ovf   = (d1 == MIN_VAL) && (d2 == '1);
      div_s_den = (div_zero || div_ovf) ? DATA_W'(1) : d2;
      div_u_den = div_zero ? DATA_W'(1) : d2;
      q_s       = $signed(d1) / $signed(div_s_den);
      r_s       = $signed(d1) % $signed(div_s_den);
      q_u       = d1 / div_u_den;
      r_u       = d1 % div_u_den;
   end

   // Select the result for the requested operation
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      case (op)
         MD_MULT: {res_hi, res_lo} = prod_s;
         MD_MULTU: {res_hi, res_lo} = prod_u;
`ifdef MD_MADD_EN
         MD_MADD, MD_MSUB: {res_hi, res_lo} = prod_s;
         MD_MADDU, MD_MSUBU: {res_hi, res_lo} = prod_u;
`endif
         MD_DIV: begin
            if (div_zero) begin
               res_hi = d1;
               res_lo = '1;
            end else if (div_ovf) begin
               res_hi = '0;
               res_lo = MIN_VAL;
            end else begin
               res_hi = r_s;
               res_lo = q_s;
            end
         end
         MD_DIVU: begin
            if (div_zero) begin
               res_hi = d1;
               res_lo = '1;
            end else begin
               res_hi = r_u;
               res_lo = q_u;
            end
         end
         default: begin
            res_hi = '0;
            res_lo = '0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit_param.sv
// md_unit_param: multi-cycle multiply/divide unit holding the HI/LO registers.
// A latency counter models the fixed multi-cycle latency; busy = (cnt != 0).
// Optional feature macro: MD_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate into
// {hi,lo} at the completion edge).
`timescale 1ns/1ps
module md_unit_param
   import md_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MD_OP_W-1:0] op,
   input  logic [DATA_W-1:0]  d1,
   input  logic [DATA_W-1:0]  d2,
   input  logic               cancel,
   output logic               busy,
   output logic [DATA_W-1:0]  hi,
   output logic [DATA_W-1:0]  lo
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W-1:0] res_q;
   logic [2*DATA_W-1:0] hilo_nxt;
   logic [DATA_W-1:0]   dp_hi;
   logic [DATA_W-1:0]   dp_lo;
   logic                accept;
   logic                done;
`ifdef MD_MADD_EN
   md_acc_e             acc_q;
`endif

   md_datapath #(
      .DATA_W (DATA_W)
   ) u_datapath (
      .op     (op),
      .d1     (d1),
      .d2     (d2),
      .res_hi (dp_hi),
      .res_lo (dp_lo)
   );

   // Handshake decode: acceptance and the result-commit (1->0) edge
   always_comb begin
      busy   = (cnt != '0);
      accept = start && !busy && !cancel && is_legal(op);
      done   = busy && !cancel && (cnt == CNT_W'(1));
   end

   // Value committed to {hi,lo} on completion (accumulate only when enabled)
   always_comb begin
      hilo_nxt = res_q;
`ifdef MD_MADD_EN
      case (acc_q)
         ACC_ADD: hilo_nxt = {hi, lo} + res_q;
         ACC_SUB: hilo_nxt = {hi, lo} - res_q;
         default: hilo_nxt = res_q;
      endcase
`endif
   end

   // Latency counter and latched result; cancel flushes the in-flight op
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         res_q <= '0;
`ifdef MD_MADD_EN
         acc_q <= ACC_NONE;
`endif
      end else if (busy) begin
         cnt <= cancel ? '0 : (cnt - CNT_W'(1));
      end else if (accept && is_arith(op)) begin
         cnt   <= CNT_W'(lat_of(op, MULT_LAT, DIV_LAT));
         res_q <= {dp_hi, dp_lo};
`ifdef MD_MADD_EN
         acc_q <= acc_of(op);
`endif
      end
   end

   // HI/LO architectural registers: commit on completion, or direct MTHI/MTLO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (done) begin
         {hi, lo} <= hilo_nxt;
      end else if (accept && (op == MD_MTHI)) begin
         hi <= d1;
      end else if (accept && (op == MD_MTLO)) begin
         lo <= d1;
      end
   end

endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param: directed cases followed by random
// traffic compared against a behavioural model of HI/LO and op latency.
`timescale 1ns/1ps
module tb_md_unit_param;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] d1;
   logic [31:0] d2;
   logic        cancel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // reference model state
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int          m_rem;
   logic [63:0] m_res;
   int          m_kind;

   always #5 clk = ~clk;

   md_unit_param #(
      .DATA_W   (32),
      .MULT_LAT (5),
      .DIV_LAT  (10)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .d1     (d1),
      .d2     (d2),
      .cancel (cancel),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic m_legal(input logic [3:0] o);
      case (o)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8: return 1'b1;
`ifdef MD_MADD_EN
         4'd9, 4'd10, 4'd11, 4'd12: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] m_calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      int              ia;
      int              ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      ia = a;
      ib = b;
      case (o)
         4'd1, 4'd9, 4'd11: return 64'(sa * sb);
         4'd2, 4'd10, 4'd12: return 64'(ua * ub);
         4'd3: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(ia % ib), 32'(ia / ib)};
         end
         4'd4: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   // Advance the model across one rising edge with the given inputs
   task automatic model_step(input bit s, input logic [3:0] o, input logic [31:0] a,
                             input logic [31:0] b, input bit c);
      logic [63:0] acc;
      if (m_rem > 0) begin
         if (c) begin
            m_rem = 0;
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               acc = {m_hi, m_lo};
               if (m_kind == 1) acc = acc + m_res;
               else if (m_kind == 2) acc = acc - m_res;
               else acc = m_res;
               {m_hi, m_lo} = acc;
            end
         end
      end else if (s && !c && m_legal(o)) begin
         if (o == 4'd7) m_hi = a;
         else if (o == 4'd8) m_lo = a;
         else begin
            m_res  = m_calc(o, a, b);
            m_kind = (o == 4'd9 || o == 4'd10) ? 1 : ((o == 4'd11 || o == 4'd12) ? 2 : 0);
            m_rem  = (o == 4'd3 || o == 4'd4) ? 10 : 5;
         end
      end
   endtask

   // One clock: check outputs at the falling edge, then drive the next inputs
   task automatic cycle(input bit s, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit c);
      @(negedge clk);
      chk("busy", {63'h0, busy}, {63'h0, (m_rem != 0)});
      chk("hi", {32'h0, hi}, {32'h0, m_hi});
      chk("lo", {32'h0, lo}, {32'h0, m_lo});
      start  = s;
      op     = o;
      d1     = a;
      d2     = b;
      cancel = c;
      model_step(s, o, a, b, c);
   endtask

   task automatic idle();
      cycle(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
   endtask

   // Count busy cycles following an accept; bounded so a stuck busy fails
   task automatic run_to_idle(input string tag, input int exp_lat);
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         idle();
         if (busy) n++;
         else break;
      end
      chk(tag, 64'(n), 64'(exp_lat));
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      op     = 4'd0;
      d1     = 32'h0;
      d2     = 32'h0;
      cancel = 1'b0;
      m_hi   = 32'h0;
      m_lo   = 32'h0;
      m_rem  = 0;
      m_res  = 64'h0;
      m_kind = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state is checked by the first cycle()
      cycle(1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
      run_to_idle("mult_lat", 5);
      chk("mult_hi", {32'h0, hi}, 64'hFFFF_FFFF);
      chk("mult_lo", {32'h0, lo}, 64'hFFFF_FFEB);

      cycle(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
      run_to_idle("divu_lat", 10);
      chk("divu_lo", {32'h0, lo}, 64'd14);
      chk("divu_hi", {32'h0, hi}, 64'd2);

      cycle(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_to_idle("div_lat", 10);
      chk("div_lo", {32'h0, lo}, 64'hFFFF_FFFD);
      chk("div_hi", {32'h0, hi}, 64'hFFFF_FFFF);

      cycle(1'b1, MD_DIV, 32'd5, 32'd0, 1'b0);
      run_to_idle("divz_lat", 10);
      chk("divz_lo", {32'h0, lo}, 64'hFFFF_FFFF);
      chk("divz_hi", {32'h0, hi}, 64'd5);

      cycle(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_to_idle("divo_lat", 10);
      chk("divo_lo", {32'h0, lo}, 64'h8000_0000);
      chk("divo_hi", {32'h0, hi}, 64'h0);

      cycle(1'b1, MD_DIVU, 32'd9, 32'd0, 1'b0);
      run_to_idle("divuz_lat", 10);
      chk("divuz_lo", {32'h0, lo}, 64'hFFFF_FFFF);
      chk("divuz_hi", {32'h0, hi}, 64'd9);

      // MTHI writes directly without busy
      cycle(1'b1, MD_MTHI, 32'h1234, 32'h0, 1'b0);
      idle();
      chk("mthi_hi", {32'h0, hi}, 64'h1234);
      chk("mthi_busy", {63'h0, busy}, 64'h0);

      // MTLO during MULTU is ignored
      cycle(1'b1, MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
      cycle(1'b1, MD_MTLO, 32'd55, 32'h0, 1'b0);
      run_to_idle("multu_lat", 4);
      chk("multu_hi", {32'h0, hi}, 64'h1);
      chk("multu_lo", {32'h0, lo}, 64'h0);

      // cancel in flight keeps prior HI/LO
      cycle(1'b1, MD_MTHI, 32'hAAAA, 32'h0, 1'b0);
      cycle(1'b1, MD_MTLO, 32'hBBBB, 32'h0, 1'b0);
      cycle(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0);
      idle();
      idle();
      cycle(1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
      idle();
      chk("cancel_busy", {63'h0, busy}, 64'h0);
      chk("cancel_hi", {32'h0, hi}, 64'hAAAA);
      chk("cancel_lo", {32'h0, lo}, 64'hBBBB);

      // cancel together with start blocks acceptance
      cycle(1'b1, MD_MULT, 32'd2, 32'd3, 1'b1);
      idle();
      chk("cstart_busy", {63'h0, busy}, 64'h0);

      // reserved opcodes leave state untouched
      cycle(1'b1, 4'd5, 32'd1, 32'd1, 1'b0);
      cycle(1'b1, 4'd13, 32'd1, 32'd1, 1'b0);
      idle();
      chk("rsv_busy", {63'h0, busy}, 64'h0);
      chk("rsv_lo", {32'h0, lo}, 64'hBBBB);

`ifdef MD_MADD_EN
      cycle(1'b1, MD_MTHI, 32'h0, 32'h0, 1'b0);
      cycle(1'b1, MD_MTLO, 32'd10, 32'h0, 1'b0);
      cycle(1'b1, MD_MADD, 32'd2, 32'd3, 1'b0);
      run_to_idle("madd_lat", 5);
      chk("madd_lo", {32'h0, lo}, 64'd16);
      chk("madd_hi", {32'h0, hi}, 64'h0);
`else
      cycle(1'b1, MD_MADD, 32'd2, 32'd3, 1'b0);
      idle();
      chk("madd_off_busy", {63'h0, busy}, 64'h0);
`endif

      // asynchronous reset in the middle of a DIV
      cycle(1'b1, MD_MTHI, 32'h77, 32'h0, 1'b0);
      cycle(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
      idle();
      idle();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", {63'h0, busy}, 64'h0);
      chk("arst_hi", {32'h0, hi}, 64'h0);
      chk("arst_lo", {32'h0, lo}, 64'h0);
      #1 reset = 1'b0;
      m_hi  = 32'h0;
      m_lo  = 32'h0;
      m_rem = 0;

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
               $urandom_range(0, 11) == 0);
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
